// File: rtl/sdram_req_arbiter.sv
// sdram_req_arbiter: shares the sdrc_core application port between the
// video read requester (bursts) and the FTDI/USB write requester (single
// words). Reads are favoured; a write that has waited WR_MAX_WAIT cycles
// may pre-empt reads unless the video FIFO is near empty.
// Optional feature macro: ARB_STATS_EN (grant/wait statistics counters).
module sdram_req_arbiter #(
  parameter logic [8:0]  RD_LEN      = 9'd8,
  parameter logic [8:0]  WR_LEN      = 9'd1,
  parameter int unsigned GUARD_CYC   = 2,
  parameter logic [7:0]  WR_MAX_WAIT = 8'd64
) (
  input  logic        mem_clk,
  input  logic        reset_n,
  input  logic        rd_req,
  input  logic [24:0] rd_addr,
  input  logic [1:0]  fifo_level,
  output logic        rd_ack,
  input  logic        wr_req,
  input  logic [24:0] wr_addr,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        wr_data_next,
  output logic        app_req,
  output logic [24:0] app_req_addr,
  output logic [8:0]  app_req_len,
  output logic        app_req_wr_n,
  output logic        app_req_dma_last,
  output logic [15:0] app_wr_data,
  input  logic        app_req_ack,
  input  logic        app_wr_next_req,
  input  logic        app_rd_valid,
  input  logic        app_last_rd,
  output logic        busy,
  output logic [15:0] rd_grant_cnt,
  output logic [15:0] wr_grant_cnt,
  output logic [7:0]  wr_wait_max
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DATA, GUARD, WR_REQ, WR_DATA
  } state_t;

  localparam logic [1:0] GUARD_LAST = 2'((GUARD_CYC == 0) ? 0 : GUARD_CYC - 1);

  state_t      state, state_nxt;
  logic [7:0]  wr_wait;
  logic [8:0]  wr_cnt;
  logic [1:0]  guard_cnt;
  logic        force_wr;
  logic        wr_done;
  logic        unused_ok;

  assign rd_ack           = app_req_ack & (state == RD_REQ);
  assign wr_ack           = app_req_ack & (state == WR_REQ);
  // A word strobe coincident with the write ack already counts toward WR_LEN.
  assign wr_data_next     = app_wr_next_req & ((state == WR_DATA) | wr_ack);
  assign wr_done          = wr_data_next & ((wr_cnt + 9'd1) == WR_LEN);
  assign force_wr         = wr_req & (wr_wait >= WR_MAX_WAIT) & (fifo_level >= 2'd1);
  assign busy             = (state != IDLE);
  assign app_req_dma_last = app_req_wr_n;
  assign app_wr_data      = wr_data;
  assign unused_ok        = &{1'b0, app_rd_valid};

  // State register
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state decision: forced write, then read, then write
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (force_wr)    state_nxt = WR_REQ;
        else if (rd_req) state_nxt = RD_REQ;
        else if (wr_req) state_nxt = WR_REQ;
      end
      RD_REQ:  if (app_req_ack) state_nxt = RD_DATA;
      RD_DATA: if (app_last_rd) state_nxt = (GUARD_CYC == 0) ? IDLE : GUARD;
      GUARD:   if (guard_cnt == GUARD_LAST) state_nxt = IDLE;
      WR_REQ:  if (app_req_ack) state_nxt = wr_done ? IDLE : WR_DATA;
      WR_DATA: if (wr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request registers: loaded on the grant edge, held until ack
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      app_req      <= 1'b0;
      app_req_addr <= '0;
      app_req_len  <= '0;
      app_req_wr_n <= 1'b1;
    end else if (state == IDLE && state_nxt == RD_REQ) begin
      app_req      <= 1'b1;
      app_req_addr <= rd_addr;
      app_req_len  <= RD_LEN;
      app_req_wr_n <= 1'b1;
    end else if (state == IDLE && state_nxt == WR_REQ) begin
      app_req      <= 1'b1;
      app_req_addr <= wr_addr;
      app_req_len  <= WR_LEN;
      app_req_wr_n <= 1'b0;
    end else if (app_req_ack && (state == RD_REQ || state == WR_REQ)) begin
      app_req      <= 1'b0;
    end
  end

  // Guard-cycle and write-word counters
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      guard_cnt <= '0;
      wr_cnt    <= '0;
    end else begin
      guard_cnt <= (state == GUARD) ? guard_cnt + 2'd1 : '0;
      if (state == IDLE)     wr_cnt <= '0;
      else if (wr_data_next) wr_cnt <= wr_cnt + 9'd1;
    end
  end

  // Write wait counter: saturating, cleared on write ack
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n)
      wr_wait <= '0;
    else if (wr_ack)
      wr_wait <= '0;
    else if (wr_req && state != WR_REQ && state != WR_DATA && wr_wait != '1)
      wr_wait <= wr_wait + 8'd1;
  end

`ifdef ARB_STATS_EN
  // Grant statistics and worst observed write wait
  always_ff @(posedge mem_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_grant_cnt <= '0;
      wr_grant_cnt <= '0;
      wr_wait_max  <= '0;
    end else begin
      if (rd_ack) rd_grant_cnt <= rd_grant_cnt + 16'd1;
      if (wr_ack) begin
        wr_grant_cnt <= wr_grant_cnt + 16'd1;
        if (wr_wait > wr_wait_max) wr_wait_max <= wr_wait;
      end
    end
  end
`else
  assign rd_grant_cnt = '0;
  assign wr_grant_cnt = '0;
  assign wr_wait_max  = '0;
`endif

endmodule
